// File: rtl/cost_vec_packer.sv
// Serial-to-packed cost vector assembler: gathers ArrL cost elements into one
// vector for the max-index finder, with a spare assembly buffer behind the output register.
module cost_vec_packer #(
    parameter int                    data_depth = 8,
    parameter int                    ArrL       = 4,
    parameter int                    IdxDept    = 10,
    parameter logic [data_depth-1:0] PadVal     = '0
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       en,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [data_depth-1:0]      in_data,
    input  logic                       in_last,
    output logic [data_depth*ArrL-1:0] DOut,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic                       out_err,
    output logic [IdxDept-1:0]         fill_idx
);

    localparam int VW = data_depth * ArrL;
    localparam logic [IdxDept-1:0] LAST_IDX = IdxDept'(ArrL - 1);

    localparam logic [0:0] ST_FILL = 1'b0;
    localparam logic [0:0] ST_PEND = 1'b1;

    logic [0:0]         state_q, state_d;
    logic [IdxDept-1:0] fill_idx_q, fill_idx_d;
    logic [VW-1:0]      buf_q, buf_d;
    logic               err_q, err_d;
    logic [VW-1:0]      dout_q, dout_d;
    logic               out_valid_q, out_valid_d;
    logic               out_err_q, out_err_d;

    logic          in_acc;
    logic          out_fire;
    logic          out_free;
    logic          at_last;
    logic          close;
    logic          frame_err;
    logic [VW-1:0] asm_vec;

    assign in_ready  = en && (state_q == ST_FILL);
    assign in_acc    = in_valid && in_ready;
    assign out_fire  = out_valid_q && out_ready && en;
    assign out_free  = !out_valid_q || out_fire;
    assign at_last   = (fill_idx_q == LAST_IDX);
    assign close     = in_acc && (at_last || in_last);
    // A close without in_last can only happen at the last slot, i.e. a long frame.
    assign frame_err = !(in_last && at_last);

    // Buffer with the incoming element placed; a closing in_last pads the slots above it.
    always_comb begin
        asm_vec = buf_q;
        for (int k = 0; k < ArrL; k++) begin
            if (IdxDept'(k) == fill_idx_q) begin
                asm_vec[k*data_depth +: data_depth] = in_data;
            end else if (IdxDept'(k) > fill_idx_q && in_last) begin
                asm_vec[k*data_depth +: data_depth] = PadVal;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        fill_idx_d  = fill_idx_q;
        buf_d       = buf_q;
        err_d       = err_q;
        dout_d      = dout_q;
        out_valid_d = out_valid_q;
        out_err_d   = out_err_q;

        if (en) begin
            if (out_fire) begin
                out_valid_d = 1'b0;
            end

            case (state_q)
                ST_FILL: begin
                    if (in_acc) begin
                        buf_d      = asm_vec;
                        fill_idx_d = close ? '0 : fill_idx_q + 1'b1;
                        if (close) begin
                            if (out_free) begin
                                dout_d      = asm_vec;
                                out_err_d   = frame_err;
                                out_valid_d = 1'b1;
                            end else begin
                                err_d   = frame_err;
                                state_d = ST_PEND;
                            end
                        end
                    end
                end
                ST_PEND: begin
                    if (out_free) begin
                        dout_d      = buf_q;
                        out_err_d   = err_q;
                        out_valid_d = 1'b1;
                        state_d     = ST_FILL;
                    end
                end
                default: state_d = ST_FILL;
            endcase
        end
    end

    // NOTE: every register, the assembly buffer included, is cleared by reset so a
    // short frame after reset can never expose stale slots; all state uses <=.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_FILL;
            fill_idx_q  <= '0;
            buf_q       <= '0;
            err_q       <= 1'b0;
            dout_q      <= '0;
            out_valid_q <= 1'b0;
            out_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            fill_idx_q  <= fill_idx_d;
            buf_q       <= buf_d;
            err_q       <= err_d;
            dout_q      <= dout_d;
            out_valid_q <= out_valid_d;
            out_err_q   <= out_err_d;
        end
    end

    assign DOut      = dout_q;
    assign out_valid = out_valid_q;
    assign out_err   = out_err_q;
    assign fill_idx  = fill_idx_q;

endmodule

// File: tb/tb_cost_vec_packer.sv
// Bench for cost_vec_packer: directed scenarios then random traffic, all checked
// against a frame-level model built on an element queue and a packing function.
module tb_cost_vec_packer;

    localparam int DD = 8;
    localparam int AL = 4;
    localparam int IW = 10;
    localparam logic [DD-1:0] PAD = 8'h00;

    logic           clk = 1'b0;
    logic           rst_n;
    logic           en;
    logic           in_valid;
    logic           in_ready;
    logic [DD-1:0]  in_data;
    logic           in_last;
    logic [DD*AL-1:0] DOut;
    logic           out_valid;
    logic           out_ready;
    logic           out_err;
    logic [IW-1:0]  fill_idx;

    int total = 0;
    int bad   = 0;

    // model state
    int              cur[$];
    bit              m_pend;
    logic [DD*AL-1:0] m_pvec;
    bit              m_perr;
    bit              m_ov;
    bit              m_oerr;
    logic [DD*AL-1:0] m_dout;

    cost_vec_packer #(.data_depth(DD), .ArrL(AL), .IdxDept(IW), .PadVal(PAD)) dut (
        .clk(clk), .rst_n(rst_n), .en(en),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
        .DOut(DOut), .out_valid(out_valid), .out_ready(out_ready), .out_err(out_err),
        .fill_idx(fill_idx)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [DD*AL-1:0] pack(input int q[$]);
        logic [DD*AL-1:0] v;
        for (int k = 0; k < AL; k++)
            v[k*DD +: DD] = (k < q.size()) ? q[k][DD-1:0] : PAD;
        return v;
    endfunction

    // One clock: drive inputs, check in_ready, advance the model, check outputs after the edge.
    task automatic step(input logic v, input logic [DD-1:0] d, input logic l,
                        input logic ordy, input logic e, input logic r = 1'b1);
        bit in_rdy, in_acc, ofire, ofree;
        logic [DD*AL-1:0] vec;
        bit verr;
        rst_n = r; en = e; in_valid = v; in_data = d; in_last = l; out_ready = ordy;
        #1;
        in_rdy = e && !m_pend;
        check("in_ready", 64'(in_ready), 64'(in_rdy));
        if (!r) begin
            cur.delete(); m_pend = 0; m_perr = 0; m_ov = 0; m_oerr = 0; m_dout = '0;
        end else if (e) begin
            in_acc = v && in_rdy;
            ofire  = m_ov && ordy;
            ofree  = !m_ov || ofire;
            if (ofire) m_ov = 0;
            if (m_pend) begin
                if (ofree) begin
                    m_dout = m_pvec; m_oerr = m_perr; m_ov = 1; m_pend = 0;
                end
            end else if (in_acc) begin
                cur.push_back(int'(d));
                if (cur.size() == AL || l) begin
                    vec  = pack(cur);
                    verr = l ? (cur.size() < AL) : 1'b1;
                    cur.delete();
                    if (ofree) begin
                        m_dout = vec; m_oerr = verr; m_ov = 1;
                    end else begin
                        m_pvec = vec; m_perr = verr; m_pend = 1;
                    end
                end
            end
        end
        @(posedge clk);
        #1;
        check("out_valid", 64'(out_valid), 64'(m_ov));
        check("DOut",      64'(DOut),      64'(m_dout));
        check("out_err",   64'(out_err),   64'(m_oerr));
        check("fill_idx",  64'(fill_idx),  64'(cur.size()));
    endtask

    task automatic idle(input logic ordy, input logic e = 1'b1);
        step(1'b0, 8'h00, 1'b0, ordy, e);
    endtask

    initial begin
        rst_n = 0; en = 1; in_valid = 0; in_data = 0; in_last = 0; out_ready = 0;
        cur.delete(); m_pend = 0; m_pvec = '0; m_perr = 0; m_ov = 0; m_oerr = 0; m_dout = '0;
        @(posedge clk); #1;

        // reset, then basic frame 10,20,30,40
        step(0, 0, 0, 1, 1, 0);
        check("reset_out_valid", 64'(out_valid), 64'(0));
        check("reset_fill_idx",  64'(fill_idx),  64'(0));
        step(1, 8'd10, 0, 1, 1);
        step(1, 8'd20, 0, 1, 1);
        step(1, 8'd30, 0, 1, 1);
        step(1, 8'd40, 1, 1, 1);
        check("basic_vec", 64'(DOut), 64'h281E140A);
        check("basic_err", 64'(out_err), 64'(0));
        idle(1);

        // backpressure: two frames held, then drained back to back
        for (int i = 1; i <= 8; i++) step(1, 8'(i), (i % 4) == 0, 0, 1);
        check("held_vec", 64'(DOut), 64'h04030201);
        idle(0);
        idle(1);
        check("drain_second", 64'(DOut), 64'h08070605);
        idle(1);
        idle(1);

        // short frame 9,8
        step(1, 8'd9, 0, 1, 1);
        step(1, 8'd8, 1, 1, 1);
        check("short_vec", 64'(DOut), 64'h00000809);
        check("short_err", 64'(out_err), 64'(1));
        idle(1);

        // long frame 1..6 with in_last only on 6
        for (int i = 1; i <= 6; i++) begin
            step(1, 8'(i), i == 6, 1, 1);
            if (i == 4) check("long_vec", 64'(DOut), 64'h04030201);
        end
        check("long_tail_vec", 64'(DOut), 64'h00000605);
        check("long_tail_err", 64'(out_err), 64'(1));
        idle(1);

        // en toggling mid-frame and while a vector is held
        step(1, 8'hA1, 0, 0, 1);
        step(1, 8'hA2, 0, 1, 0);
        step(1, 8'hA2, 0, 1, 1);
        step(1, 8'hA3, 0, 0, 1);
        step(1, 8'hA4, 1, 0, 1);
        step(1, 8'hB1, 0, 1, 0);
        step(1, 8'hB1, 0, 1, 0);
        check("en_frozen_vec", 64'(DOut), 64'hA4A3A2A1);
        idle(1);
        idle(1);

        // reset with a vector pending and a partial frame in progress
        for (int i = 1; i <= 8; i++) step(1, 8'(16 + i), (i % 4) == 0, 0, 1);
        step(1, 8'h31, 0, 0, 1);
        step(1, 8'h32, 0, 0, 1);
        step(0, 0, 0, 0, 1, 0);
        check("rst_mid_valid", 64'(out_valid), 64'(0));
        check("rst_mid_fill",  64'(fill_idx),  64'(0));
        for (int i = 0; i < 4; i++) step(1, 8'(8'h41 + i), i == 3, 1, 1);
        check("post_rst_vec", 64'(DOut), 64'h44434241);

        // random traffic
        for (int n = 0; n < 400; n++) begin
            step($urandom_range(0, 3) != 0, 8'($urandom), $urandom_range(0, 6) == 0,
                 $urandom_range(0, 4) < 3, $urandom_range(0, 9) != 0,
                 $urandom_range(0, 99) != 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
